axi5_sub_mem: RTL and testbench
===============================

Name: axi5_sub_mem

Overview:
Parametrised AXI5 subordinate memory that responds on all five channels (AW, W, B, AR, R). It has independent write and read engines, supports FIXED, INCR and WRAP bursts with byte strobes, and signals decode and slave errors. It replaces fixed-width slave models in the verification environment and is the reusable responder for any bus width.

Parameters:
DATA_W, 16, data bus width in bits (power of 2, ≥16); BYTES = DATA_W/8
ADDR_W, 64, address width in bits
ID_W, 8, transaction ID width in bits
DEPTH, 1024, memory size in DATA_W words; word index = addr >> log2(BYTES)

Ports:
clk  in  1  clock, all logic on posedge
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address accept
AWADDR  in  ADDR_W  write start address
AWID  in  ID_W  write ID
AWLEN  in  8  beats minus 1
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WVALID  in  1  write data valid
WREADY  out  1  write data accept
WDATA  in  DATA_W  write data
WSTRB  in  BYTES  byte enables
WLAST  in  1  last write beat
BVALID  out  1  write response valid
BREADY  in  1  write response accept
BID  out  ID_W  = captured AWID
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
ARVALID  in  1  read address valid
ARREADY  out  1  read address accept
ARADDR  in  ADDR_W  read start address
ARID  in  ID_W  read ID
ARLEN  in  8  beats minus 1
ARBURST  in  2  as AWBURST
RVALID  out  1  read data valid
RREADY  in  1  read data accept
RDATA  out  DATA_W  read data
RID  out  ID_W  = captured ARID
RRESP  out  2  per-beat response
RLAST  out  1  final read beat

Behaviour:
- Reset (async, ARESETn=0): write FSM to W_IDLE, read FSM to R_IDLE. All outputs go to 0, except AWREADY=1 and ARREADY=1 after reset releases. Memory contents are not cleared. A reset mid-burst abandons the burst; no B or R is issued for it.
- Beats are always full width; addresses are aligned down to BYTES. Next address rules:
  - FIXED: address is unchanged.
  - INCR: address += BYTES.
  - WRAP: valid only for len 1, 3, 7 or 15. Wraps within an aligned (len+1)*BYTES window.
- Error rules, evaluated once at address accept:
  - Reserved burst, or WRAP with an illegal len: SLVERR for the whole burst.
  - Any beat word index ≥ DEPTH: DECERR for that beat. That beat does no memory access, and reads return 0.
  - For writes, BRESP is the worst per-burst error, with precedence DECERR > SLVERR > OKAY.
- Write FSM:
  - W_IDLE: AWREADY=1. On the AW handshake, capture ID/addr/len/burst and go to W_DATA the next cycle, with AWREADY=0.
  - W_DATA: WREADY=1. Each W handshake writes the bytes with WSTRB[i]=1 and increments the beat counter. On the handshake where count==len, go to W_RESP.
  - If WLAST disagrees with count==len on any beat, BRESP=SLVERR (the write still happens). Beats continue until count==len.
  - W_RESP: BVALID=1, and BID/BRESP are held stable until BREADY. Then go to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On the AR handshake, capture the fields and go to R_DATA.
  - R_DATA: the first RVALID asserts 1 cycle after the AR handshake, with RDATA registered from memory.
  - While RVALID=1 and RREADY=0, RDATA/RID/RRESP/RLAST hold stable.
  - On a handshake, the next beat is presented the next cycle (back-to-back, 1 beat per cycle). RLAST=1 on beat len.
  - After the RLAST handshake, go to R_IDLE with ARREADY=1 in the following cycle.
- Engines are independent; read and write bursts overlap freely. If a read beat is fetched in the same cycle as a write to the same word, the read returns the old data.
- One outstanding transaction per direction; there is no AW/AR queueing.

Test Plan:
- DATA_W=32, AW addr 0x10, INCR, len 3, WDATA 0xA0..0xA3, WSTRB 0xF -> BRESP 00, BID=AWID. Then AR with the same parameters -> RDATA 0xA0..0xA3, RLAST on beat 3, first RVALID 1 cycle after the AR handshake.
- WRAP len 3 at addr 0x18 (DATA_W=32) -> beats written at 0x18, 0x1C, 0x10, 0x14. Read back INCR from 0x10 -> data in order 3rd, 4th, 1st, 2nd. WRAP len 2 -> BRESP 10.
- WSTRB 0x5 over word 0xFFFFFFFF with WDATA 0x11223344 -> readback 0xFF22FF44. FIXED len 3 to one address -> last beat's data wins.
- AWADDR beyond DEPTH*BYTES -> BRESP 11 and memory unchanged. A read there -> RDATA 0, RRESP 11 on every beat.
- RREADY held low for 5 cycles mid-burst -> RDATA/RLAST stable. Also cover BREADY low for 3 cycles, WLAST early on beat 1 of len 3 (-> BRESP 10), and ARESETn pulsed mid-read (-> RVALID=0 immediately, ARREADY=1 after release).

Source files
------------

// File: rtl/axi5_sub_mem_if.sv
// axi5_sub_mem_if: the five AXI5 channels (AW, W, B, AR, R) between a manager and axi5_sub_mem.
interface axi5_sub_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8
);
    localparam int BYTES = DATA_W / 8;

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [ID_W-1:0]   AWID;
    logic [7:0]        AWLEN;
    logic [1:0]        AWBURST;

    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [BYTES-1:0]  WSTRB;
    logic              WLAST;

    logic              BVALID;
    logic              BREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;

    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [ID_W-1:0]   ARID;
    logic [7:0]        ARLEN;
    logic [1:0]        ARBURST;

    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [ID_W-1:0]   RID;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        output ARVALID, ARADDR, ARID, ARLEN, ARBURST,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP,
        input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST
    );

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        input  ARVALID, ARADDR, ARID, ARLEN, ARBURST,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP,
        output ARREADY, RVALID, RDATA, RID, RRESP, RLAST
    );
endinterface

// File: rtl/axi5_sub_mem.sv
// axi5_sub_mem: AXI5 subordinate memory with independent write and read engines,
// FIXED/INCR/WRAP bursts, byte strobes, and SLVERR/DECERR signalling.
// Bursts with a reserved type or an illegal WRAP length answer SLVERR and touch no memory.
module axi5_sub_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              ARESETn,
    axi5_sub_mem_if.slave     bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BYTES - 1);
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> LOG2B) >= ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> LOG2B);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] mask;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << LOG2B) - ADDR_W'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + ADDR_W'(BYTES)) & mask);
            default: return a + ADDR_W'(BYTES);
        endcase
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_t           w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst, w_resp;
    logic              w_berr, w_final, w_oob, aw_hs, w_hs;

    rstate_t           r_state, r_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr, f_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst, r_resp;
    logic [DATA_W-1:0] r_data;
    logic              r_berr, r_final, f_berr, f_oob, ar_hs, r_hs;
    logic [IDX_W-1:0]  f_idx;

    assign aw_hs   = bus.AWVALID && bus.AWREADY;
    assign w_hs    = bus.WVALID && bus.WREADY;
    assign w_final = (w_cnt == w_len);
    assign w_oob   = out_of_range(w_addr);
    assign bus.BID   = w_id;
    assign bus.BRESP = w_resp;

    // Write engine state register.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write engine next state and channel ready/valid outputs.
    always_comb begin
        w_next      = w_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = ARESETn;
                if (bus.AWVALID && ARESETn) w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: capture on AW, advance address and fold in the worst response per beat.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_berr  <= 1'b0;
            w_resp  <= OKAY;
        end else if (aw_hs) begin
            w_id    <= bus.AWID;
            w_addr  <= align(bus.AWADDR);
            w_len   <= bus.AWLEN;
            w_burst <= bus.AWBURST;
            w_cnt   <= '0;
            w_berr  <= burst_err(bus.AWBURST, bus.AWLEN);
            w_resp  <= burst_err(bus.AWBURST, bus.AWLEN) ? SLVERR : OKAY;
        end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_len, w_burst);
            w_cnt   <= w_cnt + 8'd1;
            w_resp  <= worst(w_resp, worst(w_oob ? DECERR : OKAY,
                                           (bus.WLAST != w_final) ? SLVERR : OKAY));
        end
    end

    // Byte-strobed memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_oob && !w_berr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.WDATA[8*i +: 8];
            end
        end
    end

    assign ar_hs     = bus.ARVALID && bus.ARREADY;
    assign r_hs      = bus.RVALID && bus.RREADY;
    assign r_final   = (r_cnt == r_len);
    assign f_oob     = out_of_range(f_addr);
    assign f_idx     = word_idx(f_addr);
    assign bus.RDATA = r_data;
    assign bus.RID   = r_id;
    assign bus.RRESP = r_resp;
    assign bus.RLAST = (r_state == R_DATA) && r_final;

    // Read engine state register.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read engine next state and channel ready/valid outputs.
    always_comb begin
        r_next      = r_state;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = ARESETn;
                if (bus.ARVALID && ARESETn) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                if (bus.RREADY && r_final) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Address of the beat to fetch next: the AR start address when idle, else the following beat.
    always_comb begin
        f_addr = next_addr(r_addr, r_len, r_burst);
        f_berr = r_berr;
        if (r_state == R_IDLE) begin
            f_addr = align(bus.ARADDR);
            f_berr = burst_err(bus.ARBURST, bus.ARLEN);
        end
    end

    // Registered read fetch; loads only on AR accept or a non-final R handshake so outputs hold under stall.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_berr  <= 1'b0;
            r_data  <= '0;
            r_resp  <= OKAY;
        end else if (ar_hs || (r_hs && !r_final)) begin
            r_addr <= f_addr;
            r_data <= (f_oob || f_berr) ? '0 : mem[f_idx];
            r_resp <= f_oob ? DECERR : (f_berr ? SLVERR : OKAY);
            if (ar_hs) begin
                r_id    <= bus.ARID;
                r_len   <= bus.ARLEN;
                r_burst <= bus.ARBURST;
                r_cnt   <= '0;
                r_berr  <= f_berr;
            end else begin
                r_cnt   <= r_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi5_sub_mem.sv
// tb_axi5_sub_mem: directed bursts against axi5_sub_mem (32-bit data) with hand-computed expectations.
module tb_axi5_sub_mem;
    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int IW    = 8;
    localparam int DEPTH = 1024;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic clk = 1'b0;
    logic ARESETn;

    int checks = 0;
    int errors = 0;

    logic [31:0] wdat [16];
    logic [31:0] rexp [16];
    logic [1:0]  rrsp [16];

    axi5_sub_mem_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

    axi5_sub_mem #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .ARESETn (ARESETn),
        .bus     (bus.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic writeBurst(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] strb, input int lastBeat,
                              input int bDelay, input logic [1:0] expResp, input string tag);
        int n;
        @(negedge clk);
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWID    = id;
        bus.AWLEN   = len;
        bus.AWBURST = burst;
        n = 0;
        while (bus.AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) checkOutput({tag, "_aw_timeout"}, 64'(0), 64'(1));
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = wdat[i];
            bus.WSTRB  = strb;
            bus.WLAST  = (i == lastBeat);
            n = 0;
            while (bus.WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) checkOutput({tag, "_w_timeout"}, 64'(0), 64'(1));
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        n = 0;
        while (bus.BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) checkOutput({tag, "_b_timeout"}, 64'(0), 64'(1));
        checkOutput({tag, "_bresp"}, 64'(bus.BRESP), 64'(expResp));
        checkOutput({tag, "_bid"}, 64'(bus.BID), 64'(id));
        repeat (bDelay) begin
            @(negedge clk);
            checkOutput({tag, "_bhold"}, 64'({bus.BVALID, bus.BRESP, bus.BID}), 64'({1'b1, expResp, id}));
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        checkOutput({tag, "_bdone"}, 64'({bus.BVALID, bus.AWREADY}), 64'(2'b01));
    endtask

    task automatic readBurst(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int stallBeat, input int stallCycles,
                             input string tag);
        int n;
        @(negedge clk);
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARID    = id;
        bus.ARLEN   = len;
        bus.ARBURST = burst;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) checkOutput({tag, "_ar_timeout"}, 64'(0), 64'(1));
        @(negedge clk);
        bus.ARVALID = 1'b0;
        checkOutput({tag, "_first_rvalid"}, 64'(bus.RVALID), 64'(1));
        for (int i = 0; i <= int'(len); i++) begin
            checkOutput({tag, "_rdata"}, 64'(bus.RDATA), 64'(rexp[i]));
            checkOutput({tag, "_rctrl"}, 64'({bus.RVALID, bus.RLAST, bus.RRESP, bus.RID}),
                        64'({1'b1, (i == int'(len)), rrsp[i], id}));
            if (i == stallBeat) begin
                bus.RREADY = 1'b0;
                repeat (stallCycles) begin
                    @(negedge clk);
                    checkOutput({tag, "_stall_rdata"}, 64'(bus.RDATA), 64'(rexp[i]));
                    checkOutput({tag, "_stall_rctrl"}, 64'({bus.RVALID, bus.RLAST, bus.RRESP}),
                                64'({1'b1, (i == int'(len)), rrsp[i]}));
                end
            end
            bus.RREADY = 1'b1;
            @(negedge clk);
        end
        bus.RREADY = 1'b0;
        checkOutput({tag, "_rdone"}, 64'({bus.RVALID, bus.ARREADY}), 64'(2'b01));
    endtask

    task automatic applyStimulus();
        // Reset values, then release.
        ARESETn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs", 64'({bus.BVALID, bus.RVALID, bus.RLAST, bus.WREADY}), 64'(0));
        ARESETn = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY}), 64'(3'b110));

        // Word 0 preload, later used to show an out-of-range write does not alias onto it.
        wdat[0] = 32'h12345678;
        writeBurst(64'h0, 8'h01, 8'd0, INCR, 4'hF, 0, 0, 2'b00, "pre0");

        // INCR write then readback, also with a 5-cycle RREADY stall.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
        writeBurst(64'h10, 8'h5A, 8'd3, INCR, 4'hF, 3, 0, 2'b00, "incr_w");
        for (int i = 0; i < 4; i++) begin rexp[i] = 32'hA0 + 32'(i); rrsp[i] = 2'b00; end
        readBurst(64'h10, 8'h33, 8'd3, INCR, -1, 0, "incr_r");
        readBurst(64'h10, 8'h34, 8'd3, INCR, 1, 5, "stall_r");

        // WRAP len 3 from 0x18 lands at 0x18, 0x1C, 0x10, 0x14; BREADY held off 3 cycles.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hB0 + 32'(i);
        writeBurst(64'h18, 8'h21, 8'd3, WRAP, 4'hF, 3, 3, 2'b00, "wrap_w");
        rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
        readBurst(64'h10, 8'h22, 8'd3, INCR, -1, 0, "wrap_r");

        // WRAP with an illegal length.
        writeBurst(64'h40, 8'h23, 8'd2, WRAP, 4'hF, 2, 0, 2'b10, "wrap_bad");

        // Partial strobes merge into the existing word.
        wdat[0] = 32'hFFFFFFFF;
        writeBurst(64'h80, 8'h40, 8'd0, INCR, 4'hF, 0, 0, 2'b00, "strb_fill");
        wdat[0] = 32'h11223344;
        writeBurst(64'h80, 8'h41, 8'd0, INCR, 4'h5, 0, 0, 2'b00, "strb_w");
        rexp[0] = 32'hFF22FF44; rrsp[0] = 2'b00;
        readBurst(64'h80, 8'h42, 8'd0, INCR, -1, 0, "strb_r");

        // FIXED burst: last beat wins.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hC0 + 32'(i);
        writeBurst(64'h90, 8'h50, 8'd3, FIXED, 4'hF, 3, 0, 2'b00, "fixed_w");
        rexp[0] = 32'hC3;
        readBurst(64'h90, 8'h51, 8'd0, INCR, -1, 0, "fixed_r");

        // Fully out of range: DECERR, no write, reads return zero.
        wdat[0] = 32'hDEADBEEF; wdat[1] = 32'hCAFEF00D;
        writeBurst(64'h2000, 8'h60, 8'd1, INCR, 4'hF, 1, 0, 2'b11, "oob_w");
        rexp[0] = 32'h12345678; rrsp[0] = 2'b00;
        readBurst(64'h0, 8'h61, 8'd0, INCR, -1, 0, "oob_alias_r");
        rexp[0] = 32'h0; rexp[1] = 32'h0; rrsp[0] = 2'b11; rrsp[1] = 2'b11;
        readBurst(64'h2000, 8'h62, 8'd1, INCR, -1, 0, "oob_r");

        // Burst crossing the top of memory: first beat lands, second is DECERR.
        wdat[0] = 32'hE0; wdat[1] = 32'hE1;
        writeBurst(64'hFFC, 8'h70, 8'd1, INCR, 4'hF, 1, 0, 2'b11, "edge_w");
        rexp[0] = 32'hE0; rexp[1] = 32'h0; rrsp[0] = 2'b00; rrsp[1] = 2'b11;
        readBurst(64'hFFC, 8'h71, 8'd1, INCR, -1, 0, "edge_r");

        // WLAST on beat 1 of a len-3 burst: SLVERR but data still written.
        for (int i = 0; i < 4; i++) wdat[i] = 32'hD0 + 32'(i);
        writeBurst(64'h100, 8'h80, 8'd3, INCR, 4'hF, 1, 0, 2'b10, "wlast_w");
        for (int i = 0; i < 4; i++) begin rexp[i] = 32'hD0 + 32'(i); rrsp[i] = 2'b00; end
        readBurst(64'h100, 8'h81, 8'd3, INCR, -1, 0, "wlast_r");

        // Reset pulsed mid-read abandons the burst; memory survives.
        @(negedge clk);
        bus.ARVALID = 1'b1;
        bus.ARADDR  = 64'h10;
        bus.ARID    = 8'h90;
        bus.ARLEN   = 8'd3;
        bus.ARBURST = INCR;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        @(negedge clk);
        checkOutput("midrst_beat1", 64'(bus.RDATA), 64'(32'hB3));
        ARESETn = 1'b0;
        #1;
        checkOutput("midrst_rvalid", 64'({bus.RVALID, bus.RLAST, bus.BVALID}), 64'(0));
        @(negedge clk);
        ARESETn = 1'b1;
        bus.RREADY = 1'b0;
        @(negedge clk);
        checkOutput("midrst_release", 64'({bus.AWREADY, bus.ARREADY, bus.RVALID}), 64'(3'b110));
        rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
        for (int i = 0; i < 4; i++) rrsp[i] = 2'b00;
        readBurst(64'h10, 8'h91, 8'd3, INCR, -1, 0, "postrst_r");
    endtask

    // Drive idle inputs, run the directed sequence, print the summary.
    initial begin
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWID = '0; bus.AWLEN = '0; bus.AWBURST = '0;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0; bus.ARBURST = '0;
        bus.RREADY  = 1'b0;
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
